// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_arb_pkg;

    localparam int unsigned WB_AW    = 5;
    localparam int unsigned WB_DW    = 32;
    localparam int unsigned REG_ZERO = 0;

    typedef struct packed {
        logic             we;
        logic [WB_AW-1:0] waddr;
        logic [WB_DW-1:0] wdata;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_LDU  = 2'd2
    } gnt_src_e;

endpackage

// File: rtl/wb_port_arb_if.sv
// Write-port bundle: pipeline request, long-latency result and register-file write.
// Statistics outputs exist only when WB_ARB_STATS_EN is defined.
interface wb_port_arb_if #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
);
    logic          pipe_we_i;
    logic [AW-1:0] pipe_waddr_i;
    logic [DW-1:0] pipe_wdata_i;
    logic          pipe_ready_o;
    logic          ldu_valid_i;
    logic [AW-1:0] ldu_waddr_i;
    logic [DW-1:0] ldu_wdata_i;
    logic          ldu_ready_o;
    logic          rf_we_o;
    logic [AW-1:0] rf_waddr_o;
    logic [DW-1:0] rf_wdata_o;
`ifdef WB_ARB_STATS_EN
    logic [31:0]   stall_cnt_o;
    logic [15:0]   squash_cnt_o;
`endif

    modport slave (
        input  pipe_we_i, pipe_waddr_i, pipe_wdata_i,
        input  ldu_valid_i, ldu_waddr_i, ldu_wdata_i,
        output pipe_ready_o, ldu_ready_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o
`ifdef WB_ARB_STATS_EN
        , output stall_cnt_o, squash_cnt_o
`endif
    );

    modport master (
        output pipe_we_i, pipe_waddr_i, pipe_wdata_i,
        output ldu_valid_i, ldu_waddr_i, ldu_wdata_i,
        input  pipe_ready_o, ldu_ready_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o
`ifdef WB_ARB_STATS_EN
        , input stall_cnt_o, squash_cnt_o
`endif
    );

endinterface

// File: rtl/wb_squash_fifo.sv
// Long-latency result FIFO with per-entry valid bits, address-match squash
// and silent removal of an invalidated head.
module wb_squash_fifo
    import wb_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = WB_AW,
    parameter int unsigned DW    = WB_DW
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [AW-1:0]                push_waddr_i,
    input  logic [DW-1:0]                push_wdata_i,
    input  logic                         grant_head_i,
    input  logic                         squash_i,
    input  logic [AW-1:0]                squash_addr_i,
    output logic                         head_valid_c,
    output logic [AW-1:0]                head_waddr_c,
    output logic [DW-1:0]                head_wdata_c,
    output logic                         full_c,
    output logic                         pop_c,
    output logic [$clog2(DEPTH+1)-1:0]   squash_num_c
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]    waddr_q [DEPTH];
    logic [AW-1:0]    waddr_d [DEPTH];
    logic [DW-1:0]    wdata_q [DEPTH];
    logic [DW-1:0]    wdata_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_c;
    logic             push_c;

    always_comb begin
        valid_d      = valid_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        squash_num_c = '0;

        empty_c      = (count_q == '0);
        full_c       = (count_q == CW'(DEPTH));
        head_valid_c = !empty_c && valid_q[rd_ptr_q];
        head_waddr_c = waddr_q[rd_ptr_q];
        head_wdata_c = wdata_q[rd_ptr_q];
        // A squashed head leaves without needing the write port.
        pop_c        = !empty_c && (grant_head_i || !valid_q[rd_ptr_q]);
        push_c       = push_i && !full_c;

        for (int i = 0; i < int'(DEPTH); i++) begin
            if (squash_i && valid_q[i] && (waddr_q[i] == squash_addr_i)) begin
                valid_d[i]   = 1'b0;
                squash_num_c = squash_num_c + CW'(1);
            end
        end

        if (pop_c) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end

        // Applied after squash so a same-cycle push stays valid.
        if (push_c) begin
            valid_d[wr_ptr_q] = 1'b1;
            waddr_d[wr_ptr_q] = push_waddr_i;
            wdata_d[wr_ptr_q] = push_wdata_i;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end

        count_d = count_q + CW'(push_c) - CW'(pop_c);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is qualified by valid bits and needs no reset.
    always_ff @(posedge clk) begin
        waddr_q <= waddr_d;
        wdata_q <= wdata_d;
    end

endmodule

// File: rtl/wb_port_arb.sv
// Register-file write-port arbiter: pipeline priority with aging override for
// buffered long-latency results. Optional counters under WB_ARB_STATS_EN.
module wb_port_arb
    import wb_arb_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned AW       = WB_AW,
    parameter int unsigned DW       = WB_DW
) (
    input  logic          clk,
    input  logic          rst,
    wb_port_arb_if.slave  bus
);

    localparam int unsigned AGEW = $clog2(MAX_WAIT+1);
    localparam int unsigned CW   = $clog2(DEPTH+1);

    logic            head_valid_c;
    logic [AW-1:0]   head_waddr_c;
    logic [DW-1:0]   head_wdata_c;
    logic            full_c;
    logic            pop_c;
    logic [CW-1:0]   squash_num_c;
    logic            push_c;
    logic            force_c;
    logic            squash_c;
    gnt_src_e        gnt_c;
    logic [AW-1:0]   g_waddr_c;
    logic [DW-1:0]   g_wdata_c;

    logic [AGEW-1:0] age_q, age_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]   rf_wdata_q, rf_wdata_d;

    wb_squash_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .push_i        (push_c),
        .push_waddr_i  (bus.ldu_waddr_i),
        .push_wdata_i  (bus.ldu_wdata_i),
        .grant_head_i  (gnt_c == GNT_LDU),
        .squash_i      (squash_c),
        .squash_addr_i (bus.pipe_waddr_i),
        .head_valid_c  (head_valid_c),
        .head_waddr_c  (head_waddr_c),
        .head_wdata_c  (head_wdata_c),
        .full_c        (full_c),
        .pop_c         (pop_c),
        .squash_num_c  (squash_num_c)
    );

    // Arbitration, aging and next output-register values.
    always_comb begin
        gnt_c      = GNT_NONE;
        g_waddr_c  = '0;
        g_wdata_c  = '0;
        age_d      = age_q;

        force_c    = (age_q == AGEW'(MAX_WAIT)) && head_valid_c;
        push_c     = bus.ldu_valid_i && !full_c;

        if (force_c) begin
            gnt_c = GNT_LDU;
        end else if (bus.pipe_we_i) begin
            gnt_c = GNT_PIPE;
        end else if (head_valid_c) begin
            gnt_c = GNT_LDU;
        end

        if (gnt_c == GNT_PIPE) begin
            g_waddr_c = bus.pipe_waddr_i;
            g_wdata_c = bus.pipe_wdata_i;
        end else if (gnt_c == GNT_LDU) begin
            g_waddr_c = head_waddr_c;
            g_wdata_c = head_wdata_c;
        end

        // Younger pipeline write to the same register kills older buffered results.
        squash_c = (gnt_c == GNT_PIPE) && (bus.pipe_waddr_i != AW'(REG_ZERO));

        if (pop_c || !head_valid_c) begin
            age_d = '0;
        end else if (age_q != AGEW'(MAX_WAIT)) begin
            age_d = age_q + AGEW'(1);
        end

        rf_we_d    = (gnt_c != GNT_NONE) && (g_waddr_c != AW'(REG_ZERO));
        rf_waddr_d = g_waddr_c;
        rf_wdata_d = g_wdata_c;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            age_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            age_q      <= age_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign bus.pipe_ready_o = !force_c;
    assign bus.ldu_ready_o  = !full_c;
    assign bus.rf_we_o      = rf_we_q;
    assign bus.rf_waddr_o   = rf_waddr_q;
    assign bus.rf_wdata_o   = rf_wdata_q;

`ifdef WB_ARB_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] squash_cnt_q, squash_cnt_d;
    logic [16:0] squash_sum_c;

    // Stall cycles wrap; squash count saturates.
    always_comb begin
        stall_cnt_d  = stall_cnt_q + 32'(bus.pipe_we_i && force_c);
        squash_sum_c = {1'b0, squash_cnt_q} + 17'(squash_num_c);
        squash_cnt_d = squash_sum_c[16] ? 16'hFFFF : squash_sum_c[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign bus.stall_cnt_o  = stall_cnt_q;
    assign bus.squash_cnt_o = squash_cnt_q;
`endif

endmodule

// File: tb/tb_wb_port_arb.sv
// Directed bench for wb_port_arb: inputs driven and outputs sampled on the falling edge.
module tb_wb_port_arb;
    import wb_arb_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    wb_port_arb_if #(.AW(WB_AW), .DW(WB_DW)) b ();

    wb_port_arb #(
        .DEPTH    (2),
        .MAX_WAIT (4),
        .AW       (WB_AW),
        .DW       (WB_DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic wb_req_t req(input logic we, input logic [4:0] a, input logic [31:0] d);
        wb_req_t r;
        r.we    = we;
        r.waddr = a;
        r.wdata = d;
        return r;
    endfunction

    task automatic drive_pipe(input wb_req_t r);
        b.pipe_we_i    = r.we;
        b.pipe_waddr_i = r.waddr;
        b.pipe_wdata_i = r.wdata;
    endtask

    task automatic drive_ldu(input wb_req_t r);
        b.ldu_valid_i = r.we;
        b.ldu_waddr_i = r.waddr;
        b.ldu_wdata_i = r.wdata;
    endtask

    task automatic idle();
        drive_pipe(req(1'b0, 5'd0, 32'h0));
        drive_ldu(req(1'b0, 5'd0, 32'h0));
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        step();
        step();
        vectors++; if ({b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o} !== 38'h0) begin miscompares++; $display("FAIL reset_rf: got %h want 0", {b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o}); end
        vectors++; if (b.pipe_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_pipe_ready: got %b want 1", b.pipe_ready_o); end
        vectors++; if (b.ldu_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ldu_ready: got %b want 1", b.ldu_ready_o); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_pipe_only();
        drive_pipe(req(1'b1, 5'd3, 32'hA5A5A5A5));
        vectors++; if (b.pipe_ready_o !== 1'b1) begin miscompares++; $display("FAIL pipe_ready: got %b want 1", b.pipe_ready_o); end
        step();
        vectors++; if ({b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o} !== {1'b1, 5'd3, 32'hA5A5A5A5}) begin miscompares++; $display("FAIL pipe_write: got %h want %h", {b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o}, {1'b1, 5'd3, 32'hA5A5A5A5}); end
        vectors++; if (b.pipe_ready_o !== 1'b1) begin miscompares++; $display("FAIL pipe_ready_after: got %b want 1", b.pipe_ready_o); end
        idle();
        step();
        vectors++; if ({b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o} !== 38'h0) begin miscompares++; $display("FAIL pipe_nogrant: got %h want 0", {b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o}); end
    endtask

    task automatic test_idle_drain();
        drive_ldu(req(1'b1, 5'd7, 32'h1234));
        vectors++; if (b.ldu_ready_o !== 1'b1) begin miscompares++; $display("FAIL drain_ldu_ready0: got %b want 1", b.ldu_ready_o); end
        step();
        idle();
        vectors++; if (b.rf_we_o !== 1'b0) begin miscompares++; $display("FAIL drain_early: got %b want 0", b.rf_we_o); end
        vectors++; if (b.ldu_ready_o !== 1'b1) begin miscompares++; $display("FAIL drain_ldu_ready1: got %b want 1", b.ldu_ready_o); end
        step();
        vectors++; if ({b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o} !== {1'b1, 5'd7, 32'h1234}) begin miscompares++; $display("FAIL drain_write: got %h want %h", {b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o}, {1'b1, 5'd7, 32'h1234}); end
        vectors++; if (b.ldu_ready_o !== 1'b1) begin miscompares++; $display("FAIL drain_ldu_ready2: got %b want 1", b.ldu_ready_o); end
        step();
        vectors++; if (b.rf_we_o !== 1'b0) begin miscompares++; $display("FAIL drain_after: got %b want 0", b.rf_we_o); end
    endtask

    task automatic test_starvation();
        drive_ldu(req(1'b1, 5'd9, 32'h99));
        drive_pipe(req(1'b1, 5'd1, 32'h101));
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) drive_ldu(req(1'b0, 5'd0, 32'h0));
            vectors++; if ({b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o} !== {1'b1, 5'(k), 32'h100 + 32'(k)}) begin miscompares++; $display("FAIL starve_pipe_%0d: got %h want %h", k, {b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o}, {1'b1, 5'(k), 32'h100 + 32'(k)}); end
            vectors++; if (b.pipe_ready_o !== (k < 5)) begin miscompares++; $display("FAIL starve_ready_%0d: got %b want %b", k, b.pipe_ready_o, (k < 5)); end
            drive_pipe(req(1'b1, 5'(k + 1), 32'h100 + 32'(k + 1)));
        end
        step();
        vectors++; if ({b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o} !== {1'b1, 5'd9, 32'h99}) begin miscompares++; $display("FAIL starve_forced: got %h want %h", {b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o}, {1'b1, 5'd9, 32'h99}); end
        vectors++; if (b.pipe_ready_o !== 1'b1) begin miscompares++; $display("FAIL starve_resume_ready: got %b want 1", b.pipe_ready_o); end
        step();
        vectors++; if ({b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o} !== {1'b1, 5'd6, 32'h106}) begin miscompares++; $display("FAIL starve_held: got %h want %h", {b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o}, {1'b1, 5'd6, 32'h106}); end
        idle();
        step();
    endtask

    task automatic test_squash();
        drive_ldu(req(1'b1, 5'd5, 32'h555));
        drive_pipe(req(1'b1, 5'd8, 32'h808));
        step();
        vectors++; if ({b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o} !== {1'b1, 5'd8, 32'h808}) begin miscompares++; $display("FAIL squash_pre: got %h want %h", {b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o}, {1'b1, 5'd8, 32'h808}); end
        drive_ldu(req(1'b0, 5'd0, 32'h0));
        drive_pipe(req(1'b1, 5'd5, 32'h5AFE));
        step();
        vectors++; if ({b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o} !== {1'b1, 5'd5, 32'h5AFE}) begin miscompares++; $display("FAIL squash_pipe: got %h want %h", {b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o}, {1'b1, 5'd5, 32'h5AFE}); end
        idle();
        step();
        vectors++; if ({b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o} !== 38'h0) begin miscompares++; $display("FAIL squash_dropped: got %h want 0", {b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o}); end
        vectors++; if (b.pipe_ready_o !== 1'b1) begin miscompares++; $display("FAIL squash_ready: got %b want 1", b.pipe_ready_o); end
        step();
        vectors++; if (b.rf_we_o !== 1'b0) begin miscompares++; $display("FAIL squash_empty: got %b want 0", b.rf_we_o); end
        // Same-cycle push to the granted pipeline address survives.
        drive_ldu(req(1'b1, 5'd12, 32'hC));
        drive_pipe(req(1'b1, 5'd12, 32'hAAA));
        step();
        idle();
        vectors++; if ({b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o} !== {1'b1, 5'd12, 32'hAAA}) begin miscompares++; $display("FAIL samecyc_pipe: got %h want %h", {b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o}, {1'b1, 5'd12, 32'hAAA}); end
        step();
        vectors++; if ({b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o} !== {1'b1, 5'd12, 32'hC}) begin miscompares++; $display("FAIL samecyc_ldu: got %h want %h", {b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o}, {1'b1, 5'd12, 32'hC}); end
        step();
        vectors++; if (b.rf_we_o !== 1'b0) begin miscompares++; $display("FAIL samecyc_after: got %b want 0", b.rf_we_o); end
    endtask

    task automatic test_full_zero();
        vectors++; if (b.ldu_ready_o !== 1'b1) begin miscompares++; $display("FAIL full_ready0: got %b want 1", b.ldu_ready_o); end
        drive_ldu(req(1'b1, 5'd20, 32'h20));
        drive_pipe(req(1'b1, 5'd1, 32'h201));
        step();
        vectors++; if (b.ldu_ready_o !== 1'b1) begin miscompares++; $display("FAIL full_ready1: got %b want 1", b.ldu_ready_o); end
        vectors++; if ({b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o} !== {1'b1, 5'd1, 32'h201}) begin miscompares++; $display("FAIL full_pipe1: got %h want %h", {b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o}, {1'b1, 5'd1, 32'h201}); end
        drive_ldu(req(1'b1, 5'd21, 32'h21));
        drive_pipe(req(1'b1, 5'd2, 32'h202));
        step();
        vectors++; if (b.ldu_ready_o !== 1'b0) begin miscompares++; $display("FAIL full_ready_full: got %b want 0", b.ldu_ready_o); end
        vectors++; if ({b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o} !== {1'b1, 5'd2, 32'h202}) begin miscompares++; $display("FAIL full_pipe2: got %h want %h", {b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o}, {1'b1, 5'd2, 32'h202}); end
        drive_ldu(req(1'b1, 5'd22, 32'h22));
        drive_pipe(req(1'b1, 5'd0, 32'hDEAD));
        step();
        vectors++; if ({b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o} !== {1'b0, 5'd0, 32'hDEAD}) begin miscompares++; $display("FAIL zero_reg: got %h want %h", {b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o}, {1'b0, 5'd0, 32'hDEAD}); end
        vectors++; if (b.ldu_ready_o !== 1'b0) begin miscompares++; $display("FAIL full_hold: got %b want 0", b.ldu_ready_o); end
        drive_pipe(req(1'b0, 5'd0, 32'h0));
        step();
        vectors++; if ({b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o} !== {1'b1, 5'd20, 32'h20}) begin miscompares++; $display("FAIL full_drain20: got %h want %h", {b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o}, {1'b1, 5'd20, 32'h20}); end
        vectors++; if (b.ldu_ready_o !== 1'b1) begin miscompares++; $display("FAIL full_ready_free: got %b want 1", b.ldu_ready_o); end
        step();
        drive_ldu(req(1'b0, 5'd0, 32'h0));
        vectors++; if ({b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o} !== {1'b1, 5'd21, 32'h21}) begin miscompares++; $display("FAIL full_drain21: got %h want %h", {b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o}, {1'b1, 5'd21, 32'h21}); end
        step();
        vectors++; if ({b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o} !== {1'b1, 5'd22, 32'h22}) begin miscompares++; $display("FAIL full_drain22: got %h want %h", {b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o}, {1'b1, 5'd22, 32'h22}); end
        step();
        vectors++; if (b.rf_we_o !== 1'b0) begin miscompares++; $display("FAIL full_after: got %b want 0", b.rf_we_o); end
    endtask

`ifdef WB_ARB_STATS_EN
    task automatic test_stats();
        vectors++; if (b.stall_cnt_o !== 32'd1) begin miscompares++; $display("FAIL stall_cnt: got %0d want 1", b.stall_cnt_o); end
        vectors++; if (b.squash_cnt_o !== 16'd1) begin miscompares++; $display("FAIL squash_cnt: got %0d want 1", b.squash_cnt_o); end
    endtask
`endif

    task automatic test_reset_mid();
        drive_ldu(req(1'b1, 5'd30, 32'h30));
        drive_pipe(req(1'b1, 5'd1, 32'h1));
        step();
        drive_ldu(req(1'b1, 5'd31, 32'h31));
        drive_pipe(req(1'b1, 5'd2, 32'h2));
        step();
        vectors++; if (b.ldu_ready_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_full: got %b want 0", b.ldu_ready_o); end
        idle();
        rst = 1'b0;
        step();
        vectors++; if ({b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o} !== 38'h0) begin miscompares++; $display("FAIL rstmid_rf: got %h want 0", {b.rf_we_o, b.rf_waddr_o, b.rf_wdata_o}); end
        vectors++; if ({b.pipe_ready_o, b.ldu_ready_o} !== 2'b11) begin miscompares++; $display("FAIL rstmid_ready: got %b want 11", {b.pipe_ready_o, b.ldu_ready_o}); end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++; if (b.rf_we_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_nowrite_%0d: got %b want 0", k, b.rf_we_o); end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        idle();
        test_reset();
        test_pipe_only();
        test_idle_drain();
        test_starvation();
        test_squash();
        test_full_zero();
`ifdef WB_ARB_STATS_EN
        test_stats();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
